cache_miss_refill: RTL and testbench

- Miss handler for the 4-way, 64-set, 64-byte-line cache. It sits directly downstream of the LRU victim-way selector.
- On a miss it latches the selected victim way and writes the victim back to memory if it is dirty.
- It then fetches the new line as 16 x 32-bit beats and writes the line into the chosen way.
- Finally it pulses the LRU update so the filled way becomes most-recently-used.

---
 rtl/cache_pkg.sv | 18 +
 rtl/cache_miss_refill_line_assembler.sv | 25 ++
 rtl/cache_miss_refill.sv | 127 ++++++++++++
 tb/tb_cache_miss_refill.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry, FSM states and one-hot way constants for the cache miss handler
package cache_pkg;
    localparam int WAYS     = 4;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 6;
    localparam int TAG_W    = 20;
    localparam int BEATS    = 16;
    localparam int LINE_W   = 512;
    localparam int CNT_W    = $clog2(BEATS);
    typedef enum logic [2:0] {IDLE, WB_REQ, RD_REQ, RECV, FILL, DONE} state_t;
    localparam logic [WAYS-1:0] WAY0 = 4'b0001;
    localparam logic [WAYS-1:0] WAY1 = 4'b0010;
    localparam logic [WAYS-1:0] WAY2 = 4'b0100;
    localparam logic [WAYS-1:0] WAY3 = 4'b1000;
    function automatic logic is_onehot(input logic [WAYS-1:0] v);
        return (v != '0) && ((v & (v - WAYS'(1))) == '0);
    endfunction
endpackage

// File: rtl/cache_miss_refill_line_assembler.sv
// line_assembler: packs 32-bit return beats into a cache line, beat k at bits [32k+31:32k]
module line_assembler
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [31:0]       i_data,
    output logic [LINE_W-1:0] o_line
);
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;
    // clearing on every new fetch makes short (early-last) lines zero-padded
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt  <= '0;
            r_line <= '0;
        end else if (i_we) begin
            r_line[{r_cnt, 5'd0} +: 32] <= i_data;
            r_cnt                       <= r_cnt + CNT_W'(1);
        end
    end
    assign o_line = r_line;
endmodule

// File: rtl/cache_miss_refill.sv
// cache_miss_refill: victim writeback, 16-beat line fetch, way fill and LRU touch for one miss
module cache_miss_refill
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [31:0]         miss_addr,
    input  logic [WAYS-1:0]     way_sel,
    input  logic                victim_valid,
    input  logic                victim_dirty,
    input  logic [TAG_W-1:0]    victim_tag,
    input  logic [LINE_W-1:0]   victim_line,
    output logic                wr_req,
    output logic [31:0]         wr_addr,
    output logic [LINE_W-1:0]   wr_data,
    input  logic                wr_rdy,
    output logic                rd_req,
    output logic [31:0]         rd_addr,
    input  logic                rd_rdy,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [31:0]         ret_data,
    output logic [WAYS-1:0]     fill_en,
    output logic [INDEX_W-1:0]  fill_index,
    output logic [TAG_W-1:0]    fill_tag,
    output logic [LINE_W-1:0]   fill_data,
    output logic                lru_en,
    output logic [WAYS-1:0]     lru_visit,
    output logic                miss_ack
);
    state_t              r_state;
    logic [TAG_W-1:0]    r_tag;
    logic [TAG_W-1:0]    r_vtag;
    logic [INDEX_W-1:0]  r_index;
    logic [LINE_W-1:0]   r_vline;
    logic [WAYS-1:0]     r_way;
    logic [WAYS-1:0]     r_fill_en;
    logic                r_wr_req;
    logic                r_rd_req;
    logic                r_lru_en;
    logic                r_miss_ack;
    logic                w_wb;
    logic                w_clr;
    logic                w_we;
    logic [LINE_W-1:0]   w_line;
    logic                w_unused;

    assign w_wb     = victim_valid & victim_dirty;
    assign w_clr    = (r_state == RD_REQ) && rd_rdy;
    assign w_we     = (r_state == RECV) && ret_valid;
    assign w_unused = ^miss_addr[OFFSET_W-1:0];

    line_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_we   (w_we),
        .i_data (ret_data),
        .o_line (w_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tag      <= '0;
            r_vtag     <= '0;
            r_index    <= '0;
            r_vline    <= '0;
            r_way      <= '0;
            r_fill_en  <= '0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_lru_en   <= 1'b0;
            r_miss_ack <= 1'b0;
        end else begin
            r_fill_en  <= '0;
            r_lru_en   <= 1'b0;
            r_miss_ack <= 1'b0;
            case (r_state)
                IDLE: if (miss_req) begin
                    r_tag    <= miss_addr[31 -: TAG_W];
                    r_index  <= miss_addr[OFFSET_W +: INDEX_W];
                    r_vtag   <= victim_tag;
                    r_vline  <= victim_line;
                    r_way    <= is_onehot(way_sel) ? way_sel : WAY0;
                    r_wr_req <= w_wb;
                    r_rd_req <= !w_wb;
                    r_state  <= w_wb ? WB_REQ : RD_REQ;
                end
                WB_REQ: if (wr_rdy) begin
                    r_wr_req <= 1'b0;
                    r_rd_req <= 1'b1;
                    r_state  <= RD_REQ;
                end
                RD_REQ: if (rd_rdy) begin
                    r_rd_req <= 1'b0;
                    r_state  <= RECV;
                end
                RECV: if (ret_valid && ret_last) begin
                    r_fill_en <= r_way;
                    r_lru_en  <= 1'b1;
                    r_state   <= FILL;
                end
                FILL: begin
                    r_miss_ack <= 1'b1;
                    r_state    <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_req     = r_wr_req;
    assign wr_addr    = {r_vtag, r_index, {OFFSET_W{1'b0}}};
    assign wr_data    = r_vline;
    assign rd_req     = r_rd_req;
    assign rd_addr    = {r_tag, r_index, {OFFSET_W{1'b0}}};
    assign fill_en    = r_fill_en;
    assign fill_index = r_index;
    assign fill_tag   = r_tag;
    assign fill_data  = w_line;
    assign lru_en     = r_lru_en;
    assign lru_visit  = r_fill_en;
    assign miss_ack   = r_miss_ack;
endmodule

// File: tb/tb_cache_miss_refill.sv
// tb_cache_miss_refill: directed misses with a queue scoreboard checked by a negedge monitor
module tb_cache_miss_refill;
    import cache_pkg::*;

    typedef struct {
        logic [3:0]   way;
        logic [5:0]   idx;
        logic [19:0]  tag;
        logic [511:0] data;
        int           cyc;
    } fill_t;
    typedef struct {
        logic [31:0]  addr;
        logic [511:0] data;
    } wb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_req = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic [3:0]   way_sel = '0;
    logic         victim_valid = 1'b0;
    logic         victim_dirty = 1'b0;
    logic [19:0]  victim_tag = '0;
    logic [511:0] victim_line = '0;
    logic         wr_rdy = 1'b0;
    logic         rd_rdy = 1'b1;
    logic         ret_valid = 1'b0;
    logic         ret_last = 1'b0;
    logic [31:0]  ret_data = '0;
    logic         wr_req;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic [3:0]   fill_en;
    logic [5:0]   fill_index;
    logic [19:0]  fill_tag;
    logic [511:0] fill_data;
    logic         lru_en;
    logic [3:0]   lru_visit;
    logic         miss_ack;

    int    n_tests = 0;
    int    n_fail = 0;
    int    n_ack = 0;
    int    cyc = 0;
    int    last_fill = -10;
    fill_t fq[$];
    wb_t   wbq[$];
    wb_t   cur_wb;
    logic  wb_act = 1'b0;

    cache_miss_refill dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .way_sel      (way_sel),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_line  (victim_line),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_last     (ret_last),
        .ret_data     (ret_data),
        .fill_en      (fill_en),
        .fill_index   (fill_index),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .lru_en       (lru_en),
        .lru_visit    (lru_visit),
        .miss_ack     (miss_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_req"}, wr_req, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_fill_en"}, fill_en, 0);
        chk({tag, "_lru_en"}, lru_en, 0);
        chk({tag, "_lru_visit"}, lru_visit, 0);
        chk({tag, "_miss_ack"}, miss_ack, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_fill_index"}, fill_index, 0);
        chk({tag, "_fill_tag"}, fill_tag, 0);
        chk({tag, "_fill_data"}, fill_data, 0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [3:0] way, input logic valid,
                           input logic dirty, input logic [19:0] vtag, input logic [511:0] vline,
                           input int wr_delay, input int nbeats, input logic [31:0] base,
                           input logic [3:0] exp_way, input int exp_lat, input logic keep);
        fill_t f;
        wb_t   w;
        logic  wb;
        int    t_acc;
        wb = valid & dirty;
        miss_req = 1'b1;
        miss_addr = addr;
        way_sel = way;
        victim_valid = valid;
        victim_dirty = dirty;
        victim_tag = vtag;
        victim_line = vline;
        tick();
        t_acc = cyc;
        victim_tag = ~vtag;
        victim_line = ~vline;
        chk("accept_wr_req", wr_req, wb);
        chk("accept_rd_req", rd_req, !wb);
        chk("rd_addr", rd_addr, {addr[31:6], 6'b0});
        if (wb) begin
            w.addr = {vtag, addr[11:6], 6'b0};
            w.data = vline;
            wbq.push_back(w);
        end
        f.way = exp_way;
        f.idx = addr[11:6];
        f.tag = addr[31:12];
        f.data = '0;
        for (int k = 0; k < nbeats; k++) f.data[32*k +: 32] = base + 32'(k);
        f.cyc = (exp_lat >= 0) ? t_acc + exp_lat : -1;
        fq.push_back(f);
        if (wb) begin
            repeat (wr_delay) tick();
            wr_rdy = 1'b1;
            tick();
            wr_rdy = 1'b0;
        end
        for (int i = 0; i < 20 && !rd_req; i++) tick();
        chk("rd_req_seen", rd_req, 1);
        tick();
        for (int k = 0; k < nbeats; k++) begin
            ret_valid = 1'b1;
            ret_data = base + 32'(k);
            ret_last = (k == nbeats - 1);
            tick();
        end
        ret_valid = 1'b0;
        ret_last = 1'b0;
        for (int i = 0; i < 10 && !miss_ack; i++) tick();
        chk("miss_ack_seen", miss_ack, 1);
        if (!keep) miss_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            wb_act = 1'b0;
        end else begin
            if (wr_req) begin
                if (!wb_act) begin
                    chk("wb_expected", wbq.size() != 0, 1);
                    if (wbq.size() != 0) begin
                        cur_wb = wbq.pop_front();
                        wb_act = 1'b1;
                    end
                end
                if (wb_act) begin
                    chk("wr_addr", wr_addr, cur_wb.addr);
                    chk("wr_data", wr_data, cur_wb.data);
                    chk("rd_req_during_wb", rd_req, 0);
                end
            end else begin
                wb_act = 1'b0;
            end
            if (fill_en != 0 || lru_en) begin
                chk("fill_expected", fq.size() != 0, 1);
                if (fq.size() != 0) begin
                    fill_t e;
                    e = fq.pop_front();
                    chk("fill_en", fill_en, e.way);
                    chk("lru_en", lru_en, 1);
                    chk("lru_visit", lru_visit, e.way);
                    chk("fill_index", fill_index, e.idx);
                    chk("fill_tag", fill_tag, e.tag);
                    chk("fill_data", fill_data, e.data);
                    if (e.cyc >= 0) chk("fill_cycle", cyc, e.cyc);
                    last_fill = cyc;
                end
            end
            if (miss_ack) begin
                n_ack++;
                chk("ack_cycle", cyc, last_fill + 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        do_miss(32'h0000_1A40, 4'b0100, 1'b1, 1'b0, 20'h0, '0, 0, 16, 32'h100, 4'b0100, 17, 1'b0);
        tick();
        do_miss(32'h0000_2A40, 4'b0010, 1'b1, 1'b1, 20'hABCDE, {8{64'h0123_4567_89AB_CDEF}},
                3, 16, 32'h1000, 4'b0010, 21, 1'b0);
        tick();
        do_miss(32'h1234_5680, 4'b1000, 1'b0, 1'b1, 20'hFFFFF, {16{32'hCAFE_F00D}},
                0, 16, 32'h2000, 4'b1000, 17, 1'b0);
        tick();
        do_miss(32'h0000_3FC0, 4'b0001, 1'b1, 1'b0, 20'h0, '0, 0, 4, 32'h3000, 4'b0001, 5, 1'b0);
        tick();
        miss_req = 1'b1;
        miss_addr = 32'h0000_0F80;
        way_sel = 4'b1000;
        victim_valid = 1'b0;
        victim_dirty = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            ret_valid = 1'b1;
            ret_data = 32'hBAD0 + 32'(k);
            tick();
        end
        ret_valid = 1'b0;
        miss_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("abort");
        tick();
        do_miss(32'h0000_0040, 4'b0100, 1'b1, 1'b0, 20'h0, '0, 0, 2, 32'h5000, 4'b0100, 3, 1'b0);
        tick();
        do_miss(32'h0000_1000, 4'b0000, 1'b0, 1'b0, 20'h0, '0, 0, 16, 32'h6000, 4'b0001, 17, 1'b1);
        tick();
        chk("no_accept_in_done_rd", rd_req, 0);
        chk("no_accept_in_done_wr", wr_req, 0);
        do_miss(32'h0000_2000, 4'b1010, 1'b1, 1'b0, 20'h0, '0, 0, 16, 32'h7000, 4'b0001, 17, 1'b0);
        repeat (3) tick();
        chk("fill_queue_drained", fq.size(), 0);
        chk("wb_queue_drained", wbq.size(), 0);
        chk("ack_count", n_ack, 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
